count_display_driver: RTL and testbench

- Downstream consumer of the 4-bit complex counter's Count bus.
- Samples Count and converts it to two BCD digits (tens/ones, 0-15).
- Drives a time-multiplexed pair of active-low 7-segment digits through a refresh prescaler and a digit-select FSM.
- Flags value changes and wrap events for the board-level status LEDs.

---
 rtl/count_display_driver.sv | 134 +++++++++++++
 tb/tb_count_display_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/count_display_driver.sv
// Samples a 4-bit count and drives two multiplexed active-low 7-segment digits.
// Optional macro DISPLAY_HEX_EN selects single-digit hex mode.
module count_display_driver #(
  parameter int REFRESH_DIV   = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [3:0] Count,
  input  logic       Hold,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic       Changed,
  output logic       Wrapped
);

  localparam logic [0:0]  ST_ONES   = 1'b0;
  localparam logic [0:0]  ST_TENS   = 1'b1;
  localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  logic [3:0]  r_count;
  logic        r_changed;
  logic        r_wrapped;
  logic [15:0] r_presc;
  logic [0:0]  r_state;
  logic [6:0]  r_seg;
  logic [1:0]  r_an;

  logic        w_tick;
  logic        w_diff;
  logic        w_wrap;
  logic [6:0]  w_seg_next;
  logic [1:0]  w_an_next;

  // Active-low {g,f,e,d,c,b,a}; codes without a glyph stay dark.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] p;
    p = SEG_BLANK;
    case (d)
      4'd0: p = 7'b1000000;
      4'd1: p = 7'b1111001;
      4'd2: p = 7'b0100100;
      4'd3: p = 7'b0110000;
      4'd4: p = 7'b0011001;
      4'd5: p = 7'b0010010;
      4'd6: p = 7'b0000010;
      4'd7: p = 7'b1111000;
      4'd8: p = 7'b0000000;
      4'd9: p = 7'b0010000;
`ifdef DISPLAY_HEX_EN
      4'd10: p = 7'b0001000;
      4'd11: p = 7'b0000011;
      4'd12: p = 7'b1000110;
      4'd13: p = 7'b0100001;
      4'd14: p = 7'b0000110;
      4'd15: p = 7'b0001110;
`endif
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  assign w_tick = (r_presc == PRESC_MAX);
  assign w_diff = (Count != r_count);
  assign w_wrap = ((r_count == 4'd15) && (Count == 4'd0)) ||
                  ((r_count == 4'd0) && (Count == 4'd15));

`ifdef DISPLAY_HEX_EN
  always_comb begin
    w_seg_next = SEG_BLANK;
    w_an_next  = 2'b11;
    if (r_state == ST_ONES) begin
      w_seg_next = f_seg(r_count);
      w_an_next  = 2'b10;
    end
  end
`else
  logic       w_tens;
  logic [3:0] w_ones;

  assign w_tens = (r_count >= 4'd10);
  assign w_ones = w_tens ? (r_count - 4'd10) : r_count;

  always_comb begin
    w_seg_next = SEG_BLANK;
    w_an_next  = 2'b11;
    if (r_state == ST_ONES) begin
      w_seg_next = f_seg(w_ones);
      w_an_next  = 2'b10;
    end else if (w_tens || (BLANK_LEADING == 0)) begin
      w_seg_next = f_seg({3'b000, w_tens});
      w_an_next  = 2'b01;
    end
  end
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_count   <= 4'd0;
      r_changed <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (!Hold) begin
        r_count <= Count;
      end
      r_changed <= !Hold && w_diff;
      r_wrapped <= !Hold && w_wrap;
    end
  end

  // Output register lags state/sample by one edge, so a new sample shows on the following update.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_presc <= 16'd0;
      r_state <= ST_ONES;
      r_seg   <= SEG_BLANK;
      r_an    <= 2'b11;
    end else begin
      r_presc <= w_tick ? 16'd0 : (r_presc + 16'd1);
      if (w_tick) begin
        r_state <= (r_state == ST_ONES) ? ST_TENS : ST_ONES;
      end
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign Seg     = r_seg;
  assign An      = r_an;
  assign Changed = r_changed;
  assign Wrapped = r_wrapped;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver (REFRESH_DIV=4, BLANK_LEADING=1).
// Define DISPLAY_HEX_EN for both files to exercise the hex build.
module tb_count_display_driver;

  logic       Clk;
  logic       nReset;
  logic [3:0] Count;
  logic       Hold;
  logic [6:0] Seg;
  logic [1:0] An;
  logic       Changed;
  logic       Wrapped;

  int n_total;
  int n_passed;
  int n_edges;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] BLANK = 7'h7F;

`ifdef DISPLAY_HEX_EN
  localparam logic [6:0] EXP13_ONES     = 7'b0100001;
  localparam logic [6:0] EXP13_TENS_SEG = BLANK;
  localparam logic [1:0] EXP13_TENS_AN  = 2'b11;
  localparam logic [6:0] EXP12_ONES     = 7'b1000110;
  localparam logic [6:0] EXP12_TENS_SEG = BLANK;
  localparam logic [1:0] EXP12_TENS_AN  = 2'b11;
`else
  localparam logic [6:0] EXP13_ONES     = SEG_3;
  localparam logic [6:0] EXP13_TENS_SEG = SEG_1;
  localparam logic [1:0] EXP13_TENS_AN  = 2'b01;
  localparam logic [6:0] EXP12_ONES     = SEG_2;
  localparam logic [6:0] EXP12_TENS_SEG = SEG_1;
  localparam logic [1:0] EXP12_TENS_AN  = 2'b01;
`endif

  count_display_driver #(
    .REFRESH_DIV  (4),
    .BLANK_LEADING(1)
  ) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .Count  (Count),
    .Hold   (Hold),
    .Seg    (Seg),
    .An     (An),
    .Changed(Changed),
    .Wrapped(Wrapped)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      n_edges++;
    end
    #1;
    $display("edge %0d: Count=%0d Hold=%b Seg=%b An=%b Changed=%b Wrapped=%b",
             n_edges, Count, Hold, Seg, An, Changed, Wrapped);
  endtask

  initial begin
    n_total  = 0;
    n_passed = 0;
    n_edges  = 0;
    nReset   = 1'b0;
    Count    = 4'd0;
    Hold     = 1'b0;

    #12 nReset = 1'b1;
    #1;
    chk("rst_seg", Seg, BLANK);
    chk("rst_an", {5'b0, An}, 7'd3);
    chk("rst_changed", {6'b0, Changed}, 7'd0);
    chk("rst_wrapped", {6'b0, Wrapped}, 7'd0);

    step(1);  // edge 1: ones slot shows 0
    chk("zero_seg", Seg, SEG_0);
    chk("zero_an", {5'b0, An}, 7'd2);
    chk("zero_changed", {6'b0, Changed}, 7'd0);

    Count = 4'd9;
    step(1);  // edge 2
    chk("nine_changed", {6'b0, Changed}, 7'd1);
    step(1);  // edge 3
    chk("nine_changed_off", {6'b0, Changed}, 7'd0);
    chk("nine_ones_seg", Seg, SEG_9);
    chk("nine_ones_an", {5'b0, An}, 7'd2);
    step(2);  // edge 5: tens slot blanked
    chk("nine_tens_an", {5'b0, An}, 7'd3);
    chk("nine_tens_seg", Seg, BLANK);
    step(3);  // edge 8: still tens slot
    chk("nine_tens_an_end", {5'b0, An}, 7'd3);
    step(1);  // edge 9: back to ones slot
    chk("nine_ones_again_an", {5'b0, An}, 7'd2);
    chk("nine_ones_again_seg", Seg, SEG_9);

    Count = 4'd13;
    step(2);  // edge 11
    chk("thirteen_ones_seg", Seg, EXP13_ONES);
    chk("thirteen_ones_an", {5'b0, An}, 7'd2);
    step(2);  // edge 13: tens slot
    chk("thirteen_tens_seg", Seg, EXP13_TENS_SEG);
    chk("thirteen_tens_an", {5'b0, An}, {5'b0, EXP13_TENS_AN});

    Count = 4'd15;
    step(1);  // edge 14: 13->15, no wrap
    chk("to15_changed", {6'b0, Changed}, 7'd1);
    chk("to15_wrapped", {6'b0, Wrapped}, 7'd0);
    Count = 4'd0;
    step(1);  // edge 15: 15->0
    chk("wrap_dn_changed", {6'b0, Changed}, 7'd1);
    chk("wrap_dn_wrapped", {6'b0, Wrapped}, 7'd1);
    step(1);  // edge 16
    chk("wrap_dn_changed_off", {6'b0, Changed}, 7'd0);
    chk("wrap_dn_wrapped_off", {6'b0, Wrapped}, 7'd0);
    Count = 4'd15;
    step(1);  // edge 17: 0->15
    chk("wrap_up_changed", {6'b0, Changed}, 7'd1);
    chk("wrap_up_wrapped", {6'b0, Wrapped}, 7'd1);
    step(1);  // edge 18
    chk("wrap_up_wrapped_off", {6'b0, Wrapped}, 7'd0);

    Count = 4'd3;
    step(2);  // edge 20: ones slot shows 3
    chk("three_seg", Seg, SEG_3);
    Hold  = 1'b1;
    Count = 4'd4;
    step(1);  // edge 21
    chk("hold_changed_a", {6'b0, Changed}, 7'd0);
    Count = 4'd5;
    step(1);  // edge 22: tens slot, 3 has no tens digit
    chk("hold_changed_b", {6'b0, Changed}, 7'd0);
    chk("hold_tens_an", {5'b0, An}, 7'd3);
    step(3);  // edge 25: ones slot, still 3
    chk("hold_seg", Seg, SEG_3);
    chk("hold_changed_c", {6'b0, Changed}, 7'd0);
    Hold = 1'b0;
    step(1);  // edge 26
    chk("release_changed", {6'b0, Changed}, 7'd1);
    step(1);  // edge 27
    chk("release_changed_off", {6'b0, Changed}, 7'd0);
    chk("release_seg", Seg, SEG_5);

    Count = 4'd12;
    step(3);  // edge 30: tens slot
    chk("twelve_tens_seg", Seg, EXP12_TENS_SEG);
    chk("twelve_tens_an", {5'b0, An}, {5'b0, EXP12_TENS_AN});

    #2 nReset = 1'b0;
    #1;
    chk("midrst_seg", Seg, BLANK);
    chk("midrst_an", {5'b0, An}, 7'd3);
    chk("midrst_changed", {6'b0, Changed}, 7'd0);
    #3 nReset = 1'b1;
    n_edges = 0;
    step(1);  // edge 1 after reset: ones slot, sample was cleared to 0
    chk("post_rst_seg", Seg, SEG_0);
    chk("post_rst_an", {5'b0, An}, 7'd2);
    chk("post_rst_changed", {6'b0, Changed}, 7'd1);
    step(1);  // edge 2
    chk("post_rst_ones_seg", Seg, EXP12_ONES);
    step(2);  // edge 4: prescaler restarted at 0, still ones
    chk("post_rst_ones_an", {5'b0, An}, 7'd2);
    step(1);  // edge 5: tens slot
    chk("post_rst_tens_an", {5'b0, An}, {5'b0, EXP12_TENS_AN});
    chk("post_rst_tens_seg", Seg, EXP12_TENS_SEG);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
